// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache front end.
// Hits are answered combinationally; misses stall fetch and refill one word from backing memory.
module icache_responder #(
  parameter int unsigned LINES = 16,
  parameter int unsigned TAG_W = 32 - 2 - $clog2(LINES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] instr_f,
  output logic        instr_valid_f,
  output logic        stall_f,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(LINES);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state, state_nxt;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [29:0]       miss_word;
  logic              discard;
  logic [15:0]       miss_cnt;
  logic              miss;
  logic              fill;
  logic              unused_pc_bits;

  assign idx            = pc_f[2 +: IDX_W];
  assign tag            = pc_f[31 -: TAG_W];
  assign unused_pc_bits = ^pc_f[1:0];
  assign mem_addr       = {miss_word, 2'b00};
  assign miss_count     = miss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs are gated by reset so the front end sees a quiet cache while reset is held.
  always_comb begin
    state_nxt     = state;
    miss          = 1'b0;
    fill          = 1'b0;
    instr_f       = '0;
    instr_valid_f = 1'b0;
    stall_f       = 1'b0;
    mem_req       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            if (!flush && valid[idx] && (tag_mem[idx] == tag)) begin
              instr_valid_f = 1'b1;
              instr_f       = data_mem[idx];
            end else begin
              stall_f = 1'b1;
              if (!flush) begin
                miss      = 1'b1;
                state_nxt = REFILL;
              end
            end
          end
        end
        REFILL: begin
          mem_req = 1'b1;
          stall_f = 1'b1;
          if (mem_ack) begin
            fill      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      miss_word <= '0;
      discard   <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      if (miss) begin
        miss_word <= pc_f[31:2];
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
      end
      // A flush during refill poisons the returning word; the flag dies with the refill.
      if (state == REFILL) discard <= fill ? 1'b0 : (discard | flush);
      if (flush)
        valid <= '0;
      else if (fill && !discard)
        valid[miss_word[IDX_W-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[miss_word[IDX_W-1:0]]  <= miss_word[29 -: TAG_W];
      data_mem[miss_word[IDX_W-1:0]] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus randomized traffic
// compared against an address-level cache model.
module tb_icache_responder;
  localparam int unsigned LINES = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_f = '0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_f;
  logic        instr_valid_f;
  logic        stall_f;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] miss_count;

  icache_responder #(.LINES(LINES)) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .fetch_en(fetch_en), .flush(flush),
    .instr_f(instr_f), .instr_valid_f(instr_valid_f), .stall_f(stall_f),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: lines keyed by full word address.
  bit          m_valid [LINES];
  logic [29:0] m_word  [LINES];
  logic [31:0] m_data  [LINES];
  bit          m_refill;
  bit          m_discard;
  logic [31:0] m_addr;
  int unsigned m_misses;

  logic [31:0] o_instr, o_addr, e_instr, e_addr;
  logic        o_valid, o_stall, o_req, e_valid, e_stall, e_req;
  logic [15:0] o_cnt, e_cnt;

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_refill = 1'b0; m_discard = 1'b0; m_addr = '0; m_misses = 0;
  endtask

  task automatic sample();
    o_instr = instr_f; o_valid = instr_valid_f; o_stall = stall_f;
    o_req = mem_req; o_addr = mem_addr; o_cnt = miss_count;
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, predict, then advance the model.
  task automatic drive_cycle(input logic fe, input logic [31:0] pc, input logic fl,
                             input logic ack, input logic [31:0] rdata);
    int unsigned widx, pidx;
    bit hit;
    @(negedge clk);
    fetch_en = fe; pc_f = pc; flush = fl; mem_ack = ack; mem_rdata = rdata;
    #1;
    sample();
    widx = (pc >> 2) % LINES;
    hit = !m_refill && fe && !fl && m_valid[widx] && (m_word[widx] == pc[31:2]);
    e_valid = hit;
    e_instr = hit ? m_data[widx] : 32'h0;
    e_stall = m_refill || (fe && !hit);
    e_req   = m_refill;
    e_addr  = m_addr;
    e_cnt   = (m_misses > 65535) ? 16'hFFFF : 16'(m_misses);
    @(posedge clk);
    if (fl) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    if (m_refill) begin
      if (ack) begin
        if (!m_discard && !fl) begin
          pidx = (m_addr >> 2) % LINES;
          m_valid[pidx] = 1'b1; m_word[pidx] = m_addr[31:2]; m_data[pidx] = rdata;
        end
        m_refill = 1'b0; m_discard = 1'b0;
      end else if (fl) m_discard = 1'b1;
    end else if (fe && !fl && !hit) begin
      m_refill = 1'b1; m_addr = {pc[31:2], 2'b00}; m_misses++;
    end
  endtask

  task automatic refill_line(input logic [31:0] pc, input int n, input logic [31:0] rdata);
    drive_cycle(1'b1, pc, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, pc, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, pc, 1'b0, 1'b1, rdata);
  endtask

  task automatic do_reset();
    @(negedge clk);
    fetch_en = 1'b1; pc_f = 32'h40; flush = 1'b0; mem_ack = 1'b0;
    #2 reset = 1'b1;
    #1 sample();
    model_clear();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_req !== 1'b0 || o_addr !== 32'h0) begin errors++; $display("FAIL reset_mem: req %b addr %h want 0 0", o_req, o_addr); end
    checks++; if (o_cnt !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", o_cnt); end
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL reset_outputs: valid %b stall %b want 0 0", o_valid, o_stall); end
  endtask

  task automatic test_cold_miss();
    int stalls = 0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b1, 32'h40, 1'b0, c == 4, 32'h2008_0005);
      if (o_stall) stalls++;
      if (c == 1) begin
        checks++; if (o_req !== 1'b1 || o_addr !== 32'h40) begin errors++; $display("FAIL cold_req: req %b addr %h want 1 00000040", o_req, o_addr); end
      end
    end
    checks++; if (stalls != 5) begin errors++; $display("FAIL cold_stall_len: got %0d want 5", stalls); end
    checks++; if (o_valid !== 1'b1 || o_instr !== 32'h2008_0005) begin errors++; $display("FAIL cold_data: valid %b instr %h want 1 20080005", o_valid, o_instr); end
    checks++; if (o_cnt !== 16'd1) begin errors++; $display("FAIL cold_count: got %0d want 1", o_cnt); end
  endtask

  task automatic test_hit();
    drive_cycle(1'b1, 32'h43, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b1 || o_stall !== 1'b0 || o_instr !== 32'h2008_0005) begin errors++; $display("FAIL hit: valid %b stall %b instr %h want 1 0 20080005", o_valid, o_stall, o_instr); end
    drive_cycle(1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_instr !== 32'h0 || o_cnt !== 16'd1) begin errors++; $display("FAIL idle_no_fetch: valid %b stall %b instr %h cnt %0d want 0 0 0 1", o_valid, o_stall, o_instr, o_cnt); end
  endtask

  task automatic test_conflict();
    refill_line(32'h80, 0, 32'hA5A5_0080);
    drive_cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b1 || o_instr !== 32'hA5A5_0080) begin errors++; $display("FAIL conflict_fill: valid %b instr %h want 1 a5a50080", o_valid, o_instr); end
    drive_cycle(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b1) begin errors++; $display("FAIL conflict_evict: valid %b stall %b want 0 1", o_valid, o_stall); end
    drive_cycle(1'b1, 32'h40, 1'b0, 1'b1, 32'h2008_0005);
    checks++; if (o_cnt !== 16'd3) begin errors++; $display("FAIL conflict_count: got %0d want 3", o_cnt); end
  endtask

  task automatic test_flush_mid_refill();
    refill_line(32'h44, 1, 32'h1111_0044);
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h100 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_refill_req: req %b addr %h valid %b want 1 00000100 0", o_req, o_addr, o_valid); end
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL flush_refill_hold: req %b want 1", o_req); end
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b1 || o_instr !== 32'h0) begin errors++; $display("FAIL flush_discard: valid %b stall %b instr %h want 0 1 0", o_valid, o_stall, o_instr); end
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b1, 32'h2222_0100);
    drive_cycle(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b1) begin errors++; $display("FAIL flush_cleared_other: valid %b stall %b want 0 1", o_valid, o_stall); end
    drive_cycle(1'b1, 32'h44, 1'b1, 1'b1, 32'h3333_0044);
    drive_cycle(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b1) begin errors++; $display("FAIL flush_ack_same_cycle: valid %b stall %b want 0 1", o_valid, o_stall); end
    drive_cycle(1'b1, 32'h44, 1'b0, 1'b1, 32'h4444_0044);
  endtask

  task automatic test_reset_mid_refill();
    drive_cycle(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    do_reset();
    drive_cycle(1'b0, 32'h200, 1'b0, 1'b1, 32'h5555_0200);
    checks++; if (o_req !== 1'b0 || o_cnt !== 16'd0) begin errors++; $display("FAIL reset_abort: req %b cnt %0d want 0 0", o_req, o_cnt); end
    drive_cycle(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b1) begin errors++; $display("FAIL reset_no_line: valid %b stall %b want 0 1", o_valid, o_stall); end
    drive_cycle(1'b1, 32'h200, 1'b0, 1'b1, 32'h6666_0200);
    checks++; if (o_cnt !== 16'd1) begin errors++; $display("FAIL reset_recount: got %0d want 1", o_cnt); end
  endtask

  task automatic test_saturation();
    logic [15:0] want [3];
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'hFFFF;
    do_reset();
    // Preload the counter near the top instead of spending 130k cycles on real misses.
    @(negedge clk);
    force dut.miss_cnt = 16'hFFFD;
    #1 release dut.miss_cnt;
    m_misses = 65533;
    for (int i = 0; i < 3; i++) begin
      refill_line(32'h40 + 32'(i * 4), 0, 32'h7000_0000 + 32'(i));
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (o_cnt !== want[i]) begin errors++; $display("FAIL saturate_%0d: got %h want %h", i, o_cnt, want[i]); end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) r[31] = 1'b1;
    return r;
  endfunction

  task automatic test_random();
    logic [31:0] pc;
    logic fe, fl, ack;
    pc = rand_pc();
    for (int c = 0; c < 3000; c++) begin
      if (!(o_stall && $urandom_range(0, 9) < 7)) pc = rand_pc();
      fe  = ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 99) < 3);
      ack = m_refill ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
      drive_cycle(fe, pc, fl, ack, $urandom);
      checks++;
      if (o_instr !== e_instr || o_valid !== e_valid || o_stall !== e_stall ||
          o_req !== e_req || o_addr !== e_addr || o_cnt !== e_cnt) begin
        errors++;
        $display("FAIL random cyc %0d pc %h: instr %h/%h valid %b/%b stall %b/%b req %b/%b addr %h/%h cnt %h/%h (got/want)",
                 c, pc, o_instr, e_instr, o_valid, e_valid, o_stall, e_stall, o_req, e_req, o_addr, e_addr, o_cnt, e_cnt);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_mid_refill();
    test_reset_mid_refill();
    test_saturation();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 Parameter: LINES, default 16, number of direct-mapped one-word lines (power of two, 2..64).
REQ-002 Parameter: TAG_W, default 32-2-log2(LINES), tag width.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: pc_f  input  32  fetch address; pc_f[1:0] ignored.
REQ-006 Port: fetch_en  input  1  fetch request this cycle.
REQ-007 Port: flush  input  1  invalidate all lines.
REQ-008 Port: instr_f  output  32  instruction for pc_f.
REQ-009 Port: instr_valid_f  output  1  instr_f valid this cycle.
REQ-010 Port: stall_f  output  1  fetch must hold pc_f and stall the front end.
REQ-011 Port: mem_req  output  1  refill request to backing memory.
REQ-012 Port: mem_addr  output  32  word-aligned refill address.
REQ-013 Port: mem_ack  input  1  backing memory returns data this cycle.
REQ-014 Port: mem_rdata  input  32  refill word, valid when mem_ack=1.
REQ-015 Port: miss_count  output  16  saturating miss counter.

Function
REQ-016 Address split: index = pc_f[2+log2(LINES)-1:2], tag = pc_f[31:2+log2(LINES)].
REQ-017 Storage: per line one valid bit, TAG_W tag, 32-bit data word.
REQ-018 FSM states: IDLE, REFILL; reset state IDLE.
REQ-019 IDLE hit (fetch_en=1, line valid, tag equal, flush=0): instr_f=data, instr_valid_f=1, stall_f=0, same cycle (combinational lookup).
REQ-020 IDLE miss (fetch_en=1, not hit, flush=0): instr_valid_f=0, stall_f=1 same cycle; latch miss address {pc_f[31:2],2'b00}; next state REFILL; miss_count increments by 1 unless at 16'hFFFF.
REQ-021 IDLE with fetch_en=0: instr_valid_f=0, stall_f=0, no state change.
REQ-022 REFILL: mem_req=1, mem_addr=latched miss address, stall_f=1, instr_valid_f=0, held constant until mem_ack.
REQ-023 REFILL with mem_ack=1: write mem_rdata, tag, valid=1 into the latched index; mem_req deasserted next cycle; next state IDLE.
REQ-024 Miss latency: with mem_ack arriving N cycles after mem_req rises (N>=0), first instr_valid_f=1 occurs N+2 cycles after the miss cycle, provided pc_f held.
REQ-025 pc_f changing during REFILL: refill still completes for the latched address; lookup in IDLE uses current pc_f.
REQ-026 flush=1 in any state: all valid bits cleared at the clock edge; instr_valid_f=0 that cycle; no miss counted.
REQ-027 flush=1 while in REFILL: outstanding request continues until mem_ack (mem_req stays high), but the returned word is discarded (line stays invalid); discard flag cleared on return to IDLE.
REQ-028 flush and mem_ack same cycle: flush wins; line not validated.
REQ-029 mem_ack while in IDLE: ignored.
REQ-030 instr_f outside a hit: 32'h0000_0000.
REQ-031 Outputs are functions of state and current inputs only; no multi-cycle combinational loops from mem_ack to mem_req.

Reset
REQ-032 reset=1 asynchronously forces: state IDLE, all valid bits 0, mem_req=0, mem_addr=0, miss_count=0, discard flag 0, instr_valid_f=0, stall_f=0.
REQ-033 Reset asserted mid-REFILL aborts the refill; a later mem_ack is ignored; tag/data arrays need not be cleared.

Verification
REQ-034 Cold miss: reset, pc_f=0x0000_0040, fetch_en=1, mem_ack 3 cycles after mem_req with rdata 0x2008_0005 -> mem_addr=0x40, stall_f high 5 cycles, then instr_f=0x2008_0005 valid, miss_count=1.
REQ-035 Hit after fill: repeat pc_f=0x40 -> instr_valid_f=1 same cycle, stall_f=0, miss_count unchanged.
REQ-036 Conflict: pc_f=0x0000_0080 (same index as 0x40 for LINES=16, different tag) -> miss, refill; subsequent 0x40 misses again, miss_count=3.
REQ-037 Flush mid-refill: miss on 0x100, assert flush 1 cycle during REFILL, ack rdata 0xDEAD_BEEF -> next lookup of 0x100 misses again; previously valid 0x40 also misses.
REQ-038 Reset mid-refill: assert reset during REFILL, then mem_ack -> mem_req=0, no line valid, miss_count=0.
REQ-039 Saturation: force 65537 misses -> miss_count=0xFFFF, no wrap.
